// File: rtl/seq_shift_add_mult.sv
// -----------------------------------------------------------------------------
// seq_shift_add_mult
//
// Sequential unsigned shift-and-add multiplier. One partial product per clock
// is accumulated through a WIDTH-bit ripple chain of 1-bit full-adder cells.
// The accepted operands are multiplied in WIDTH RUN cycles. The 2*WIDTH-bit
// product is then held until the next result overwrites it.
//
// Ports
//   clk      in   1        rising-edge clock
//   rst      in   1        asynchronous, active-high reset
//   start    in   1        multiply request, honoured only while ready=1
//   a        in   WIDTH    multiplicand (unsigned), sampled on acceptance
//   b        in   WIDTH    multiplier (unsigned), sampled on acceptance
//   ready    out  1        idle, can accept start
//   busy     out  1        multiplication in progress
//   done     out  1        one-cycle pulse, product is new
//   product  out  2*WIDTH  registered result
//
// Build option
//   SEQ_MULT_ZERO_SKIP_EN  when defined, a zero operand at acceptance bypasses
//                          RUN: product=0 is written and DONE is entered at once.
// -----------------------------------------------------------------------------

module seq_mult_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_s,
   output logic o_c
);
   assign o_s = i_a ^ i_b ^ i_c;
   assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready=1, waiting for start
// RUN   | busy=1, one add/shift per cycle, r_cnt counts down to 0
// DONE  | done=1 for one cycle, product register holds the new result
module seq_shift_add_mult #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mq;
   logic [WIDTH-1:0]     r_acc;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_product;

   logic                 w_accept;
   logic                 w_zero_op;
   logic                 w_last;
   logic [WIDTH-1:0]     w_addend;
   logic [WIDTH-1:0]     w_sum;
   logic [WIDTH:0]       w_carry;
   logic [WIDTH-1:0]     w_acc_nxt;
   logic [WIDTH-1:0]     w_mq_nxt;

   // ---------------------------------------------------------------------------
   // Full-adder ripple chain: acc + (mq[0] ? mcand : 0), carry-in 0.
   // With a zero addend the chain passes acc through and the carry-out is 0,
   // which is exactly the "no add" case, so no separate bypass mux is needed.
   // ---------------------------------------------------------------------------
   assign w_addend   = r_mq[0] ? r_mcand : '0;
   assign w_carry[0] = 1'b0;

   for (genvar g = 0; g < WIDTH; g++) begin : g_fa
      seq_mult_fa u_fa (
         .i_a (r_acc[g]),
         .i_b (w_addend[g]),
         .i_c (w_carry[g]),
         .o_s (w_sum[g]),
         .o_c (w_carry[g+1])
      );
   end

   // {c,sum,mq} >> 1 split back into the acc and mq halves; mq[0] falls off.
   assign w_acc_nxt = {w_carry[WIDTH], w_sum[WIDTH-1:1]};
   assign w_mq_nxt  = {w_sum[0], r_mq[WIDTH-1:1]};

   // ---------------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------------
   assign w_accept = (r_state == ST_IDLE) && start;
   assign w_last   = (r_cnt == '0);

`ifdef SEQ_MULT_ZERO_SKIP_EN
   assign w_zero_op = (a == '0) || (b == '0);
`else
   assign w_zero_op = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = w_zero_op ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand   <= '0;
         r_mq      <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         if (w_accept) begin
            r_mcand <= a;
            r_mq    <= b;
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH - 1);
            // Zero-skip path: the result is known without running the chain.
            if (w_zero_op) begin
               r_product <= '0;
            end
         end else if (r_state == ST_RUN) begin
            r_acc <= w_acc_nxt;
            r_mq  <= w_mq_nxt;
            if (w_last) begin
               r_product <= {w_acc_nxt, w_mq_nxt};
            end else begin
               r_cnt <= r_cnt - CW'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs decoded straight from the state register (mutually exclusive)
   // ---------------------------------------------------------------------------
   assign ready   = (r_state == ST_IDLE);
   assign busy    = (r_state == ST_RUN);
   assign done    = (r_state == ST_DONE);
   assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        ready8, busy8, done8;
   logic [15:0] product8;

   logic        start16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        ready16, busy16, done16;
   logic [31:0] product16;

   int n_cmp = 0;
   int n_err = 0;

   // Reference results: the last product each DUT should be holding.
   logic [15:0] model_p8  = '0;
   logic [31:0] model_p16 = '0;

   always #5 clk = ~clk;

   seq_shift_add_mult #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .ready(ready8), .busy(busy8), .done(done8), .product(product8)
   );

   seq_shift_add_mult #(.WIDTH(16)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
      .ready(ready16), .busy(busy16), .done(done16), .product(product16)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One directed 8-bit multiplication: start pulsed for one cycle, operands
   // scrambled while busy, edges counted from the accepting edge to done.
   task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input int exp_edges,
                       input string tag);
      int          edges;
      int          busy_n;
      bit          rdy_low;
      bit          held;
      logic [15:0] expv;
      expv = 16'(ta) * 16'(tb_);
      @(negedge clk);
      a8 = ta; b8 = tb_; start8 = 1'b1;
      chk({tag, "_ready_pre"}, 64'(ready8), 64'd1);
      @(posedge clk);
      edges = 1; busy_n = 0; rdy_low = 1'b1; held = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      while (!done8 && edges < 40) begin
         if (busy8) busy_n++;
         if (ready8) rdy_low = 1'b0;
         if (product8 !== model_p8) held = 1'b0;
         @(posedge clk);
         edges++;
         @(negedge clk);
         a8 = 8'($urandom); b8 = 8'($urandom);
      end
      chk({tag, "_edges"},   64'(edges),    64'(exp_edges));
      chk({tag, "_product"}, 64'(product8), 64'(expv));
      chk({tag, "_busy_n"},  64'(busy_n),   64'(exp_edges - 1));
      chk({tag, "_rdy_low"}, 64'(rdy_low),  64'd1);
      chk({tag, "_held"},    64'(held),     64'd1);
      model_p8 = expv;
      @(negedge clk);
      chk({tag, "_done_pulse"}, 64'(done8),    64'd0);
      chk({tag, "_ready_post"}, 64'(ready8),   64'd1);
      chk({tag, "_hold"},       64'(product8), 64'(expv));
   endtask

   initial begin : main
      int          zero_edges;
      int          no_done;
      logic [15:0] q8[$];
      logic [31:0] q16[$];
      logic [15:0] e8;
      logic [31:0] e16;
      bit          pd8, pd16;
      int          last8, last16;

`ifdef SEQ_MULT_ZERO_SKIP_EN
      zero_edges = 1;
`else
      zero_edges = 9;
`endif

      // Reset state
      #1;
      chk("rst_ready8",   64'(ready8),    64'd1);
      chk("rst_busy8",    64'(busy8),     64'd0);
      chk("rst_done8",    64'(done8),     64'd0);
      chk("rst_prod8",    64'(product8),  64'd0);
      chk("rst_ready16",  64'(ready16),   64'd1);
      chk("rst_prod16",   64'(product16), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases
      run8(8'd3,   8'd5,   9, "m3x5");
      run8(8'd255, 8'd255, 9, "m255x255");
      run8(8'd0,   8'd200, zero_edges, "m0x200");
      run8(8'd128, 8'd1,   9, "m128x1");

      // Asynchronous reset in the middle of RUN
      @(negedge clk);
      a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_ready", 64'(ready8),   64'd1);
      chk("arst_busy",  64'(busy8),    64'd0);
      chk("arst_done",  64'(done8),    64'd0);
      chk("arst_prod",  64'(product8), 64'd0);
      model_p8 = '0;
      model_p16 = '0;
      @(negedge clk);
      rst = 1'b0;
      no_done = 1;
      repeat (12) begin
         @(negedge clk);
         if (done8 || product8 !== 16'd0) no_done = 0;
      end
      chk("arst_no_done", 64'(no_done), 64'd1);
      run8(8'd7, 8'd9, 9, "m7x9");

      // Randomized back-to-back on both widths, start held high.
      pd8 = 1'b0; pd16 = 1'b0; last8 = -1; last16 = -1;
      for (int cyc = 0; cyc < 460; cyc++) begin
         @(negedge clk);
         if (done8) begin
            chk("b2b8_double_done", 64'(pd8), 64'd0);
            chk("b2b8_spurious", 64'(q8.size() != 0), 64'd1);
            e8 = (q8.size() != 0) ? q8.pop_front() : 16'hxxxx;
            chk("b2b8_product", 64'(product8), 64'(e8));
            if (last8 >= 0) chk("b2b8_period", 64'(cyc - last8), 64'd10);
            last8 = cyc;
            model_p8 = e8;
         end else begin
            chk("b2b8_stable", 64'(product8), 64'(model_p8));
         end
         if (done16) begin
            chk("b2b16_double_done", 64'(pd16), 64'd0);
            chk("b2b16_spurious", 64'(q16.size() != 0), 64'd1);
            e16 = (q16.size() != 0) ? q16.pop_front() : 32'hxxxxxxxx;
            chk("b2b16_product", 64'(product16), 64'(e16));
            if (last16 >= 0) chk("b2b16_period", 64'(cyc - last16), 64'd18);
            last16 = cyc;
            model_p16 = e16;
         end else begin
            chk("b2b16_stable", 64'(product16), 64'(model_p16));
         end
         pd8 = done8; pd16 = done16;

         start8  = (cyc < 420);
         start16 = (cyc < 420);
         a8  = 8'($urandom_range(1, 255));
         b8  = 8'($urandom_range(1, 255));
         a16 = 16'($urandom_range(1, 65535));
         b16 = 16'($urandom_range(1, 65535));
         if (ready8 && start8)   q8.push_back(16'(a8) * 16'(b8));
         if (ready16 && start16) q16.push_back(32'(a16) * 32'(b16));
      end
      chk("b2b8_drained",  64'(q8.size()),  64'd0);
      chk("b2b16_drained", 64'(q16.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
